// File: rtl/bslc.sv
// rtl/bslc.sv - barrel-shifter left-cyclic stage with fixed rotate distance and registered copy
module bslc #(
  parameter int N = 32,
  parameter int b = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic         s,
  output logic [N-1:0] z,
  output logic [N-1:0] z_q
);

  // Reject identity or out-of-range rotate distances at elaboration.
  generate
    if (N < 2) begin : g_bad_width
      $error("bslc: N must be at least 2");
    end
    if (b < 1 || b > N - 1) begin : g_bad_shift
      $error("bslc: b must lie in 1..N-1");
    end
  endgenerate

  // One 2:1 mux per bit; the rotated leg index is a constant per bit, so no
  // shifter or adder exists at runtime.
  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      localparam int SRC = (i - b + N) % N;
      assign z[i] = s ? a[SRC] : a[i];
    end
  endgenerate

  // Pipeline copy of the combinational result; reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= '0;
    end else begin
      z_q <= z;
    end
  end

endmodule

// File: tb/tb_bslc.sv
// tb/tb_bslc.sv - self-checking bench for bslc, all rotate distances in parallel
module tb_bslc;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic        s;
  logic [31:0] z_all  [1:31];
  logic [31:0] zq_all [1:31];

  int vectors;
  int miscompares;

  generate
    for (genvar g = 1; g <= 31; g++) begin : g_dut
      bslc #(.N(32), .b(g)) u_dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .s   (s),
        .z   (z_all[g]),
        .z_q (zq_all[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotation as multiply-by-2^sh in double width, folding the overflow back in.
  function automatic logic [31:0] ref_rot(input logic [31:0] x, input int sh, input logic en);
    logic [63:0] w;
    if (!en) return x;
    w = {32'b0, x} << sh;
    return w[31:0] | w[63:32];
  endfunction

  task automatic chk(input string name, input int sh, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s b=%0d got=%08h expected=%08h", name, sh, got, exp);
    end
  endtask

  typedef struct {
    int          sh;
    logic [31:0] a;
    logic        s;
    logic [31:0] z;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] prev_a;
  logic        prev_s;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    a   = 32'h0;
    s   = 1'b0;
    #1;

    // Reset state of every registered output.
    for (int k = 1; k <= 31; k++) chk("reset_zq", k, zq_all[k], 32'h0);

    tbl.push_back('{1,  32'h0000_0000, 1'b0, 32'h0000_0000});
    tbl.push_back('{17, 32'h0000_0000, 1'b0, 32'h0000_0000});
    tbl.push_back('{31, 32'h0000_0000, 1'b0, 32'h0000_0000});
    tbl.push_back('{4,  32'h1234_5678, 1'b1, 32'h2345_6781});
    tbl.push_back('{4,  32'h1234_5678, 1'b0, 32'h1234_5678});
    tbl.push_back('{1,  32'h8000_0000, 1'b1, 32'h0000_0001});
    tbl.push_back('{31, 32'h8000_0001, 1'b1, 32'hC000_0000});
    tbl.push_back('{8,  32'hDEAD_BEEF, 1'b1, 32'hADBE_EFDE});
    tbl.push_back('{16, 32'hFFFF_0000, 1'b1, 32'h0000_FFFF});
    tbl.push_back('{31, 32'h0000_0001, 1'b1, 32'h8000_0000});

    // Table vectors; z must work regardless of reset.
    for (int i = 0; i < tbl.size(); i++) begin
      a = tbl[i].a;
      s = tbl[i].s;
      #1;
      chk("table_z", tbl[i].sh, z_all[tbl[i].sh], tbl[i].z);
    end

    // Random words across every distance, rotating and passing through.
    for (int r = 0; r < 8; r++) begin
      a = $urandom();
      for (int e = 0; e < 2; e++) begin
        s = e[0];
        #1;
        for (int k = 1; k <= 31; k++) chk("rand_z", k, z_all[k], ref_rot(a, k, s));
      end
    end

    // First edge after reset release loads the current z.
    @(negedge clk);
    rst = 1'b0;
    a   = 32'hDEAD_BEEF;
    s   = 1'b1;
    @(posedge clk);
    #1;
    chk("zq_first_edge", 8, zq_all[8], 32'hADBE_EFDE);

    // Changing a between edges must not disturb z_q, while z follows.
    a = 32'h0F0F_1234;
    #2;
    chk("zq_hold", 8, zq_all[8], 32'hADBE_EFDE);
    chk("z_track", 8, z_all[8], ref_rot(32'h0F0F_1234, 8, 1'b1));
    @(posedge clk);
    #1;
    chk("zq_next_edge", 8, zq_all[8], ref_rot(32'h0F0F_1234, 8, 1'b1));

    // Asynchronous reset mid-cycle with z_q nonzero.
    rst = 1'b1;
    #1;
    for (int k = 1; k <= 31; k++) chk("async_rst_zq", k, zq_all[k], 32'h0);
    a = 32'hA5C3_9617;
    #1;
    chk("z_during_rst", 5, z_all[5], ref_rot(32'hA5C3_9617, 5, 1'b1));
    @(posedge clk);
    #1;
    chk("zq_held_in_rst", 5, zq_all[5], 32'h0);

    // Pipelined random stream: z_q reflects the previous edge's inputs.
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      a = $urandom();
      s = $urandom_range(0, 1);
      prev_a = a;
      prev_s = s;
      @(posedge clk);
      #1;
      a = ~prev_a;
      s = ~prev_s;
      for (int k = 1; k <= 31; k++) chk("pipe_zq", k, zq_all[k], ref_rot(prev_a, k, prev_s));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bslc.md
# bslc

Barrel-shifter left-cyclic stage: conditionally rotates an N-bit word left by a fixed, elaboration-time amount `b`. One instance forms one stage of the shift unit's logarithmic rotator (b = 1, 2, 4, …), or a fixed-distance rotate cell. The primary output `z` is purely combinational. A registered copy `z_q` is provided for pipelined use in the core's execute stage.

## Interface
- `N`, default 32: data width in bits; N ≥ 2.
- `b`, default 1: fixed left-rotate distance; legal range 1 ≤ b ≤ N-1; any other value is an elaboration-time error.
- `clk` input 1: clock; rising edge active; used only by `z_q`.
- `rst` input 1: reset; asynchronous, active-high; clears `z_q`.
- `a` input N: data word to rotate.
- `s` input 1: stage enable; 1 = rotate, 0 = pass through.
- `z` output N: combinational result.
- `z_q` output N: `z` registered on `clk`.

## Operation
- s = 0: z = a, bit-exact.
- s = 1: z = (a << b) | (a >> (N-b)), i.e. cyclic left rotate by b.
  - Per bit: z[i] = a[(i - b) mod N].
  - Bits shifted out of the MSB end re-enter at the LSB end.
  - Nothing is lost or zero-filled.
- Implementation: one 2:1 mux per bit, selected by `s`.
  - Leg 0 = a[i]; leg 1 = a[(i-b+N) % N].
  - Built as a generate loop over i = 0..N-1.
  - Index arithmetic resolves at elaboration; no runtime shifter, no adder.
- `z` has no dependence on `clk` or `rst`.
- X/Z on `a` propagates only to the bits it maps to.
- X on `s` may give X on any bit whose two mux legs differ.
- b = N-1 is equivalent to a right rotate by 1.
- The identity rotate (b = 0 or b = N) is not a legal parameterisation; it is rejected by the elaboration check.
- `z_q` register:
  - Rising `clk` with `rst` low: z_q ← z.
  - `rst` high: z_q = 0 immediately, independent of `clk`, held while `rst` is high.
  - Reset value of `z_q`: all zeros.
  - `z` is unaffected by reset.

## Timing
- `z`: zero-cycle latency; valid one mux delay after `a` or `s` settles.
- `z_q`: one-cycle latency.
  - Reflects the `a`/`s` sampled at the previous rising edge.
- Reset deassertion: the first rising edge after `rst` falls loads z_q with the current `z`.
- `rst` asserted coincident with a clock edge: reset wins; z_q = 0.
- No handshake, no state machine, no enable beyond `s`.
- Throughput is one word per cycle.

## Test plan
- N=32, any b in 1..31, a=0x00000000, s=0 → z=0x00000000 for every instance.
- N=32, b=4, a=0x12345678, s=1 → z=0x23456781; same a with s=0 → z=0x12345678.
- N=32, b=1, a=0x80000000, s=1 → z=0x00000001 (MSB wraps to LSB); b=31, a=0x80000001, s=1 → z=0xC0000000.
- All b=1..31 instantiated in parallel, s=1, ≥5 random a values → each z equals (a<<b)|(a>>(32-b)); s=0 → each z equals a.
- rst=1 mid-run with z_q nonzero → z_q=0x00000000 immediately, before any clk edge; `z` keeps tracking `a`.
- After rst=0, b=8, a=0xDEADBEEF, s=1, one rising clk → z_q=0xADBEEFDE; then change a → z_q holds until the next edge.
